// File: rtl/cos_detect_pkg.sv
// Shared types and helpers for the cosine period detector.
package cos_detect_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    // Sample level relative to the hysteresis band
    typedef enum logic [1:0] {
        NEG  = 2'd0,
        BAND = 2'd1,
        POS  = 2'd2
    } level_t;

    // Accumulator must hold the sum of 2**avg_log2 full-scale period counts
    function automatic int unsigned acc_width(input int unsigned cnt_width,
                                              input int unsigned avg_log2);
        return cnt_width + avg_log2;
    endfunction

endpackage

// File: rtl/hysteresis_crossing_det.sv
// Classifies each sample against +/-threshold and flags rising crossings.
module hysteresis_crossing_det
    import cos_detect_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int          HYSTERESIS = 2**28
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid,
    input  logic                         clear,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output level_t                       level_c,
    output logic                         crossing_c
);

    localparam logic signed [DATA_WIDTH-1:0] POS_TH = DATA_WIDTH'(HYSTERESIS);
    localparam logic signed [DATA_WIDTH-1:0] NEG_TH = -POS_TH;

    logic armed;

    // Level classification; the band between thresholds leaves armed untouched
    always_comb begin
        level_c = BAND;
        if (sample <= NEG_TH) begin
            level_c = NEG;
        end else if (sample >= POS_TH) begin
            level_c = POS;
        end
        crossing_c = valid && (level_c == POS) && armed;
    end

    // Armed flag: set by a negative sample, consumed by the crossing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (valid) begin
            if (clear) begin
                armed <= 1'b0;
            end else if (level_c == NEG) begin
                armed <= 1'b1;
            end else if (crossing_c) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cos_period_detector.sv
// Measures averaged samples-per-period of a valid-qualified signed tone.
module cos_period_detector
    import cos_detect_pkg::*;
#(
    parameter int unsigned INT_DATA_WIDTH = 32,
    parameter int          INT_HYSTERESIS = 2**28,
    parameter int unsigned INT_AVG_LOG2   = 2,
    parameter int unsigned INT_CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    input  logic signed [INT_DATA_WIDTH-1:0] i_sample,
    output logic                             o_valid,
    output logic        [INT_CNT_WIDTH-1:0]  o_period,
    output logic                             o_locked,
    output logic                             o_timeout
);

    localparam int unsigned CW    = INT_CNT_WIDTH;
    localparam int unsigned ACC_W = acc_width(INT_CNT_WIDTH, INT_AVG_LOG2);
    localparam int unsigned IDX_W = (INT_AVG_LOG2 == 0) ? 1 : INT_AVG_LOG2;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'((2**INT_AVG_LOG2) - 1);
    // Counter value one below saturation
    localparam logic [CW-1:0]    CNT_SAT_M1 = {{(CW-1){1'b1}}, 1'b0};

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [ACC_W-1:0]  acc, acc_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [CW-1:0]     period_d;
    logic              valid_d, locked_d, timeout_d;
    logic              clear_armed_c;
    logic [CW-1:0]     len_c;
    logic [ACC_W-1:0]  sum_c;
    level_t            level_c;
    logic              crossing_c;

    hysteresis_crossing_det #(
        .DATA_WIDTH (INT_DATA_WIDTH),
        .HYSTERESIS (INT_HYSTERESIS)
    ) u_cross (
        .clk        (clk),
        .rst        (rst),
        .valid      (i_valid),
        .clear      (clear_armed_c),
        .sample     (i_sample),
        .level_c    (level_c),
        .crossing_c (crossing_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, datapath and output decode; only accepted samples advance
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        acc_d         = acc;
        idx_d         = idx;
        period_d      = o_period;
        locked_d      = o_locked;
        valid_d       = 1'b0;
        timeout_d     = 1'b0;
        clear_armed_c = 1'b0;
        len_c         = cnt + CW'(1);
        sum_c         = acc + ACC_W'(len_c);

        if (i_valid) begin
            case (state)
                S_IDLE: begin
                    if (level_c == NEG) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (crossing_c) begin
                        cnt_d   = '0;
                        state_d = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (crossing_c) begin
                        // Crossing wins over saturation on the same sample
                        cnt_d = '0;
                        if (idx == IDX_LAST) begin
                            idx_d    = '0;
                            acc_d    = '0;
                            period_d = CW'(sum_c >> INT_AVG_LOG2);
                            valid_d  = 1'b1;
                            locked_d = 1'b1;
                        end else begin
                            idx_d = idx + IDX_W'(1);
                            acc_d = sum_c;
                        end
                    end else if (cnt == CNT_SAT_M1) begin
                        timeout_d     = 1'b1;
                        locked_d      = 1'b0;
                        acc_d         = '0;
                        idx_d         = '0;
                        cnt_d         = '0;
                        clear_armed_c = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        cnt_d = len_c;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            idx       <= '0;
            o_period  <= '0;
            o_valid   <= 1'b0;
            o_locked  <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            cnt       <= cnt_d;
            acc       <= acc_d;
            idx       <= idx_d;
            o_period  <= period_d;
            o_valid   <= valid_d;
            o_locked  <= locked_d;
            o_timeout <= timeout_d;
        end
    end

endmodule

// File: doc/cos_period_detector.md
Name: cos_period_detector

Overview:
Receive-side counterpart of the ROM cosine oscillator. It consumes a valid-qualified signed sample stream, such as o_valid/o_cos from rom_oscillator_cos. It detects rising zero crossings with hysteresis, counts accepted samples per period and averages over a power-of-two number of periods. It reports samples-per-period, so the bench and the system can check oscillator frequency without a software model.

Parameters:
INT_DATA_WIDTH, 32, width of signed input sample
INT_HYSTERESIS, 2**28, crossing threshold magnitude; must be >0 and <2**(INT_DATA_WIDTH-1)
INT_AVG_LOG2, 2, log2 of periods averaged per result (4 periods)
INT_CNT_WIDTH, 16, width of per-period counter, accumulator base width and o_period

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
i_valid  in  1  sample qualifier
i_sample  in  INT_DATA_WIDTH  signed sample
o_valid  out  1  one-cycle pulse, o_period is valid
o_period  out  INT_CNT_WIDTH  averaged samples-per-period, truncated
o_locked  out  1  level, high from first o_valid until timeout or reset
o_timeout  out  1  one-cycle pulse, period counter saturated

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM in S_IDLE, counter, accumulator and period index cleared.
- Only cycles with i_valid=1 advance anything. With i_valid=0, all state holds and pulses are 0.
- Level classification, signed compare: NEG if sample <= -INT_HYSTERESIS; POS if sample >= +INT_HYSTERESIS; otherwise BAND, which does not change the armed flag.
- Armed flag: set on NEG. A rising crossing is a POS sample while armed; the crossing clears armed.
- S_IDLE: wait for a NEG sample, then go to S_ARMED.
- S_ARMED: on the first rising crossing, load cnt=0 and go to S_MEASURE. No counting happens before this.
- S_MEASURE: each accepted sample does cnt++. When the sample is a crossing, cnt+1 is the period length:
  - add it to acc (width INT_CNT_WIDTH+INT_AVG_LOG2), reset cnt=0, increment idx.
  - When idx wraps from 2**INT_AVG_LOG2-1 to 0: register o_period = (acc+len) >> INT_AVG_LOG2, pulse o_valid, set o_locked, clear acc.
- Latency: o_valid is high in the cycle after the clock edge that accepted the final crossing sample (registered output).
- Saturation: if cnt reaches 2**INT_CNT_WIDTH-1 on a non-crossing sample, pulse o_timeout, clear o_locked, acc, idx and armed, and go to S_IDLE.
- Simultaneous events: a crossing on the saturating sample counts as a crossing, with no timeout.
- o_period holds its last value until the next o_valid. It clears only on reset.
- A reset mid-measurement discards partial results. The next result needs a re-arm plus 2**INT_AVG_LOG2 full periods.
- Period definition: count of accepted samples from the sample after one crossing up to and including the next crossing.

Decomposition:
- Shared package cos_detect_pkg holds:
  - the FSM enum typedef (S_IDLE, S_ARMED, S_MEASURE);
  - the level enum (NEG, BAND, POS);
  - a function deriving accumulator width from INT_CNT_WIDTH and INT_AVG_LOG2.
- One natural sub-module, hysteresis_crossing_det. It is registered-free combinational classify plus the armed flop, and outputs a crossing strobe.
- Counter, accumulator and FSM stay in the top.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> o_valid, o_locked, o_timeout and o_period = 0 immediately.
- Clean tone: cos at 125/25 MHz, amplitude 2**31-1, i_valid continuous for 40 samples -> first o_valid after arming plus 4 periods (about 25 samples), o_period=5, o_locked=1. Repeats every 20 samples.
- Gapped valid: same stream with i_valid=0 on every other cycle -> o_period still 5; o_valid spacing doubles to 40 cycles.
- Mixed periods: crossings spaced 5,6,5,6 samples -> o_period=5 (22>>2, truncation).
- Hysteresis and timeout (INT_CNT_WIDTH=8): after lock, feed samples alternating ±(INT_HYSTERESIS-1) -> no crossings. o_timeout pulses after 255 accepted samples, o_locked falls, and the FSM requires re-arm.
- Reset mid-measure: pulse rst after 2 of 4 periods -> no o_valid for the partial set. The next o_valid comes only after a NEG, a crossing, then 4 full periods, with o_period=5.
